// File: rtl/capture_pkg.sv
// Shared types and default sizing for the ADC capture buffer.
// Build option: define CAPTURE_TRIGGER_EN to add the level-trigger state.
package capture_pkg;

  localparam int unsigned SAMPLE_W_DEF = 12;
  localparam int unsigned DEPTH_DEF    = 10;

`ifdef CAPTURE_TRIGGER_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    TRIG  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;
`endif

endpackage

// File: rtl/capture_ram.sv
// Sample storage: DEPTH x SAMPLE_W, one synchronous write port, one
// combinational read port (the top registers the read data itself).
module capture_ram #(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned DEPTH    = 10,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [SAMPLE_W-1:0] rd_data_c
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/capture_buffer.sv
// Capture buffer: arm, collect DEPTH ADC samples, then stream them out
// oldest-first through a valid/ready handshake.
// Build option: CAPTURE_TRIGGER_EN adds trig_level and a TRIG state that
// waits for the first sample >= trig_level before filling.
module capture_buffer
  import capture_pkg::*;
#(
  parameter int unsigned SAMPLE_W = SAMPLE_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_data,
`ifdef CAPTURE_TRIGGER_EN
  input  logic [SAMPLE_W-1:0] trig_level,
`endif
  input  logic                out_ready,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_last,
  output logic                busy,
  output logic                done,
  output logic                dropped,
  output logic [CNT_W-1:0]    count
);

  localparam int unsigned      ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  function automatic logic [CNT_W-1:0] ptr_inc(input logic [CNT_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + CNT_W'(1);
  endfunction

  state_e              state, state_nxt;
  logic [CNT_W-1:0]    wr_ptr, wr_ptr_nxt;
  logic [CNT_W-1:0]    rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]    count_nxt;
  logic                out_valid_nxt, out_last_nxt, done_nxt, dropped_nxt, busy_nxt;
  logic [SAMPLE_W-1:0] out_data_nxt;
  logic                wr_en_c;
  logic [CNT_W-1:0]    rd_addr_c;
  logic [SAMPLE_W-1:0] rd_data_c;

  capture_ram #(
    .SAMPLE_W (SAMPLE_W),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_ram (
    .clk       (clk),
    .wr_en     (wr_en_c),
    .wr_addr   (ADDR_W'(wr_ptr)),
    .wr_data   (in_data),
    .rd_addr   (ADDR_W'(rd_addr_c)),
    .rd_data_c (rd_data_c)
  );

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      dropped   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
      done      <= done_nxt;
      dropped   <= dropped_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state, storage control and output staging
  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    count_nxt     = count;
    out_valid_nxt = out_valid;
    out_data_nxt  = out_data;
    out_last_nxt  = out_last;
    done_nxt      = 1'b0;
    dropped_nxt   = dropped;
    wr_en_c       = 1'b0;
    rd_addr_c     = rd_ptr;

    case (state)
      IDLE: begin
        // Samples in the arm cycle are not stored.
        if (arm) begin
          dropped_nxt = 1'b0;
`ifdef CAPTURE_TRIGGER_EN
          state_nxt   = TRIG;
`else
          state_nxt   = FILL;
`endif
        end
      end
`ifdef CAPTURE_TRIGGER_EN
      TRIG: begin
        if (in_valid && (in_data >= trig_level)) begin
          wr_en_c    = 1'b1;
          wr_ptr_nxt = ptr_inc(wr_ptr);
          count_nxt  = count + CNT_W'(1);
          state_nxt  = FILL;
        end
      end
`endif
      FILL: begin
        if (in_valid) begin
          wr_en_c    = 1'b1;
          wr_ptr_nxt = ptr_inc(wr_ptr);
          count_nxt  = count + CNT_W'(1);
          if (count == LAST_IDX) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (in_valid) dropped_nxt = 1'b1;
        if (!out_valid) begin
          // First presentation: sample at rd_ptr (always slot 0 here).
          out_valid_nxt = 1'b1;
          out_data_nxt  = rd_data_c;
          out_last_nxt  = (rd_ptr == LAST_IDX);
        end else if (out_ready) begin
          count_nxt  = count - CNT_W'(1);
          rd_ptr_nxt = ptr_inc(rd_ptr);
          if (out_last) begin
            state_nxt     = IDLE;
            done_nxt      = 1'b1;
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
          end else begin
            rd_addr_c    = ptr_inc(rd_ptr);
            out_data_nxt = rd_data_c;
            out_last_nxt = (ptr_inc(rd_ptr) == LAST_IDX);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer: directed vector table, hand-written
// corner sequences and randomized captures against a queue-based model.
module tb_capture_buffer;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned DEPTH    = 10;
  localparam int unsigned CNT_W    = $clog2(DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                arm = 1'b0;
  logic                in_valid = 1'b0;
  logic [SAMPLE_W-1:0] in_data = '0;
  logic                out_ready = 1'b0;
  logic                out_valid, out_last, busy, done, dropped;
  logic [SAMPLE_W-1:0] out_data;
  logic [CNT_W-1:0]    count;
`ifdef CAPTURE_TRIGGER_EN
  logic [SAMPLE_W-1:0] trig_level = '0;
`endif

  always #5 clk = ~clk;

  capture_buffer #(.SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .arm       (arm),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef CAPTURE_TRIGGER_EN
    .trig_level(trig_level),
`endif
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .dropped   (dropped),
    .count     (count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 fill, 2 drain, 3 trigger wait.
  // q holds every stored sample not yet handed to the writer.
  int                  ph = 0;
  logic [SAMPLE_W-1:0] q[$];
  bit                  mv = 0, mdone = 0, mdrop = 0;

  task automatic step();
    @(posedge clk);
    mdone = 0;
    if (rst) begin
      ph = 0; q.delete(); mv = 0; mdrop = 0;
    end else begin
      case (ph)
        0: if (arm) begin
          mdrop = 0; q.delete();
`ifdef CAPTURE_TRIGGER_EN
          ph = 3;
`else
          ph = 1;
`endif
        end
`ifdef CAPTURE_TRIGGER_EN
        3: if (in_valid && in_data >= trig_level) begin
          q.push_back(in_data); ph = 1;
        end
`endif
        1: if (in_valid) begin
          q.push_back(in_data);
          if (q.size() == DEPTH) ph = 2;
        end
        2: begin
          if (in_valid) mdrop = 1;
          if (!mv) mv = 1;
          else if (out_ready) begin
            void'(q.pop_front());
            if (q.size() == 0) begin mv = 0; ph = 0; mdone = 1; end
          end
        end
        default: ph = 0;
      endcase
    end
    #1;
    chk("m_out_valid", 32'(out_valid), 32'(mv));
    chk("m_busy",      32'(busy),      32'(ph != 0));
    chk("m_count",     32'(count),     32'(q.size()));
    chk("m_done",      32'(done),      32'(mdone));
    chk("m_dropped",   32'(dropped),   32'(mdrop));
    chk("m_out_last",  32'(out_last),  32'(mv && q.size() == 1));
    if (mv) chk("m_out_data", 32'(out_data), 32'(q[0]));
  endtask

  task automatic cyc(input bit r, input bit a, input bit iv, input logic [SAMPLE_W-1:0] d, input bit rdy);
    rst = r; arm = a; in_valid = iv; in_data = d; out_ready = rdy;
    step();
  endtask

  typedef struct {
    bit                  r, a, iv, rdy;
    logic [SAMPLE_W-1:0] d;
    bit                  ev, el, eb, edn;
    logic [SAMPLE_W-1:0] ed;
    int                  ecnt;
  } vec_t;

  function automatic vec_t mk(bit r, bit a, bit iv, logic [SAMPLE_W-1:0] d, bit rdy,
                              bit ev, logic [SAMPLE_W-1:0] ed, bit el, bit eb, bit edn, int ecnt);
    vec_t v;
    v.r = r; v.a = a; v.iv = iv; v.d = d; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.el = el; v.eb = eb; v.edn = edn; v.ecnt = ecnt;
    return v;
  endfunction

  initial begin
    vec_t tv[$];
    bit   seen;

    // Basic capture: reset, arm (with a sample that must be ignored),
    // samples 1..10, then a full-speed drain.
    tv.push_back(mk(1, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 0, 0));
    tv.push_back(mk(0, 1, 1, 12'h0FF, 0, 0, 12'h000, 0, 1, 0, 0));
    for (int i = 1; i <= 10; i++)
      tv.push_back(mk(0, 0, 1, 12'(i), 0, 0, 12'h000, 0, 1, 0, i));
    for (int k = 1; k <= 10; k++)
      tv.push_back(mk(0, 0, 0, 12'h000, 1, 1, 12'(k), k == 10, 1, 0, 11 - k));
    tv.push_back(mk(0, 0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 1, 0));
    tv.push_back(mk(0, 0, 0, 12'h000, 1, 0, 12'h000, 0, 0, 0, 0));

    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].r, tv[i].a, tv[i].iv, tv[i].d, tv[i].rdy);
      chk("tv_out_valid", 32'(out_valid), 32'(tv[i].ev));
      chk("tv_out_last",  32'(out_last),  32'(tv[i].el));
      chk("tv_busy",      32'(busy),      32'(tv[i].eb));
      chk("tv_done",      32'(done),      32'(tv[i].edn));
      chk("tv_count",     32'(count),     32'(tv[i].ecnt));
      if (tv[i].ev || tv[i].r) chk("tv_out_data", 32'(out_data), 32'(tv[i].ed));
      if (tv[i].r) chk("tv_dropped_rst", 32'(dropped), 32'd0);
    end

    // Writer stalled for 50 cycles, then two samples arrive during drain.
    cyc(0, 1, 0, 12'h000, 0);
    for (int i = 1; i <= 10; i++) cyc(0, 0, 1, 12'(i), 0);
    for (int i = 0; i < 50; i++) cyc(0, 0, 0, 12'h000, 0);
    chk("stall_data",  32'(out_data),  32'h001);
    chk("stall_count", 32'(count),     32'd10);
    chk("stall_valid", 32'(out_valid), 32'd1);
    cyc(0, 0, 1, 12'hABC, 0);
    cyc(0, 0, 0, 12'h000, 0);
    cyc(0, 0, 1, 12'hDEF, 0);
    chk("drop_set", 32'(dropped), 32'd1);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 12'h000, 1);
    chk("drop_sticky", 32'(dropped), 32'd1);
    cyc(0, 1, 0, 12'h000, 1);
    chk("drop_clr_arm", 32'(dropped), 32'd0);
    for (int i = 1; i <= 10; i++) cyc(0, 0, 1, 12'(i + 16), 1);
    for (int i = 0; i < 13; i++) cyc(0, 0, 0, 12'h000, 1);

    // Reset in the middle of filling abandons the capture silently.
    cyc(0, 1, 0, 12'h000, 1);
    for (int i = 1; i <= 5; i++) cyc(0, 0, 1, 12'(i + 32), 1);
    cyc(1, 0, 1, 12'h555, 1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy",  32'(busy),  32'd0);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 12'h000, 1);
      if (done) seen = 1;
    end
    chk("rst_no_done", 32'(seen), 32'd0);
    cyc(0, 1, 0, 12'h000, 1);
    for (int i = 1; i <= 10; i++) cyc(0, 0, 1, 12'(i + 48), 1);
    seen = 0;
    for (int i = 0; i < 13; i++) begin
      cyc(0, 0, 0, 12'h000, 1);
      if (done) seen = 1;
    end
    chk("rearm_done", 32'(seen), 32'd1);

    // arm repeated while filling must not restart or extend the capture.
    cyc(0, 1, 0, 12'h000, 0);
    for (int i = 1; i <= 4; i++) cyc(0, 0, 1, 12'(i + 64), 0);
    cyc(0, 1, 0, 12'h000, 0);
    for (int i = 5; i <= 7; i++) cyc(0, 0, 1, 12'(i + 64), 0);
    cyc(0, 1, 1, 12'h048, 0);
    chk("arm_fill_cnt8", 32'(count), 32'd8);
    for (int i = 9; i <= 10; i++) cyc(0, 0, 1, 12'(i + 64), 0);
    chk("arm_fill_cnt10", 32'(count), 32'd10);
    for (int i = 0; i < 13; i++) cyc(0, 0, 0, 12'h000, 1);
    chk("arm_fill_idle", 32'(busy), 32'd0);

`ifdef CAPTURE_TRIGGER_EN
    // Level trigger: samples below 0x800 are discarded.
    trig_level = 12'h800;
    cyc(0, 1, 0, 12'h000, 0);
    cyc(0, 0, 1, 12'h100, 0);
    cyc(0, 0, 1, 12'h7FF, 0);
    chk("trig_below_cnt", 32'(count), 32'd0);
    cyc(0, 0, 1, 12'h800, 0);
    chk("trig_hit_cnt", 32'(count), 32'd1);
    for (int i = 1; i <= 9; i++) cyc(0, 0, 1, 12'(i), 0);
    cyc(0, 0, 0, 12'h000, 0);
    chk("trig_first", 32'(out_data), 32'h800);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 12'h000, 1);
`endif

    // Randomized captures against the model.
    for (int c = 0; c < 40; c++) begin
      int n;
`ifdef CAPTURE_TRIGGER_EN
      trig_level = 12'($urandom_range(0, 3000));
`endif
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++)
        cyc(0, 0, 1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)));
      cyc(0, 1, 1'($urandom_range(0, 1)), 12'($urandom), 1'($urandom_range(0, 1)));
      for (int i = 0; i < 300 && ph != 0; i++)
        cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
            1'($urandom_range(0, 1)), 12'($urandom), $urandom_range(0, 2) != 0);
      chk("rand_capture_end", 32'(ph), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
